// File: rtl/capture_csr_pkg.sv
// Shared definitions for the capture engine CSR bank: word offsets,
// CONTROL bit positions, the channel block address helper and the
// encoding of the per-channel capture FSM state.
package capture_csr_pkg;

  // Global register word offsets (block 0)
  localparam logic [2:0] OFS_CONTROL  = 3'd0;
  localparam logic [2:0] OFS_STATUS   = 3'd1;
  localparam logic [2:0] OFS_IRQ_PEND = 3'd2;
  localparam logic [2:0] OFS_IRQ_MASK = 3'd3;
  localparam logic [2:0] OFS_VERSION  = 3'd4;

  // Per-channel register word offsets within a channel block
  localparam logic [2:0] OFS_BUF_BASE  = 3'd0;
  localparam logic [2:0] OFS_BUF_END   = 3'd1;
  localparam logic [2:0] OFS_WR_PTR    = 3'd2;
  localparam logic [2:0] OFS_PKT_COUNT = 3'd3;

  // CONTROL bit positions; the count-clear strobe is always the MSB
  localparam int CTRL_GLOBAL_EN = 0;
  localparam int CTRL_CH_EN_LSB = 1;

  // State reported by each channel's capture FSM
  typedef enum logic [1:0] {
    CH_IDLE    = 2'b00,
    CH_ARMED   = 2'b01,
    CH_CAPTURE = 2'b10,
    CH_STORE   = 2'b11
  } ch_state_t;

  // Word address of the first register of channel c
  function automatic int unsigned ch_block_base(input int unsigned c);
    return 8 * (c + 1);
  endfunction

endpackage

// File: rtl/capture_csr_channel.sv
// One capture channel: ring window (BUF_BASE/BUF_END), the hardware
// advanced write pointer with wrap, the saturating packet counter and
// the read mux for the channel's register block.
module capture_csr_channel
  import capture_csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr_count,
  input  logic              wr_base,
  input  logic              wr_end,
  input  logic [DATA_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        offset,
  input  logic              pkt_done,
  input  logic [DATA_W-1:0] pkt_bytes,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] buf_base,
  output logic [DATA_W-1:0] buf_end,
  output logic [DATA_W-1:0] wr_ptr,
  output logic              done_evt,
  output logic              wrap_evt
);

  logic [DATA_W-1:0] base_q, end_q, ptr_q, count_q;
  logic [DATA_W-1:0] base_next, end_next, ptr_adv;
  logic [DATA_W:0]   sum, over;
  logic              wrap_hit, accept;

  // Byte-lane merges and the wrap arithmetic for the next write pointer
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    base_next = (base_q & ~wmask) | (wdata & wmask);
    end_next  = (end_q & ~wmask) | (wdata & wmask);
    sum       = {1'b0, ptr_q} + {1'b0, pkt_bytes};
    over      = sum - {1'b0, end_q};
    wrap_hit  = (sum >= {1'b0, end_q});
    ptr_adv   = wrap_hit ? (base_q + over[DATA_W-1:0]) : sum[DATA_W-1:0];
    // A base reload in the same cycle swallows the packet entirely.
    accept    = pkt_done & en & ~wr_base;
  end

  assign done_evt = accept;
  assign wrap_evt = accept & wrap_hit;

  // Channel register state: window, write pointer, packet counter
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      end_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      if (wr_base) begin
        base_q <= base_next;
        ptr_q  <= base_next;
      end else if (accept) begin
        ptr_q <= ptr_adv;
      end
      if (wr_end) end_q <= end_next;
      if (clr_count) count_q <= '0;
      else if (accept && (count_q != '1)) count_q <= count_q + 1'b1;
    end
  end

  // Read mux for this channel's block; unused offsets read as zero
  always_comb begin
    rd_data = '0;
    case (offset)
      OFS_BUF_BASE:  rd_data = base_q;
      OFS_BUF_END:   rd_data = end_q;
      OFS_WR_PTR:    rd_data = ptr_q;
      OFS_PKT_COUNT: rd_data = count_q;
      default:       rd_data = '0;
    endcase
  end

  assign buf_base = base_q;
  assign buf_end  = end_q;
  assign wr_ptr   = ptr_q;

endmodule

// File: rtl/capture_csr_bank.sv
// Avalon-MM CSR bank for the capture engine. Holds the global CONTROL,
// STATUS, IRQ and VERSION words, decodes per-channel blocks, combines
// channel events into W1C interrupts and registers the read path.
module capture_csr_bank
  import capture_csr_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                NUM_CH  = 2,
  parameter logic [DATA_W-1:0] VERSION = DATA_W'(32'h0002_0000),
  localparam int               ADDR_W  = 3 + $clog2(NUM_CH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  output logic                     readdatavalid,
  output logic                     irq,
  input  logic [2*NUM_CH-1:0]      ch_state,
  input  logic [NUM_CH-1:0]        pkt_done,
  input  logic [DATA_W*NUM_CH-1:0] pkt_bytes,
  output logic [DATA_W-1:0]        out_control,
  output logic [DATA_W*NUM_CH-1:0] out_buf_base,
  output logic [DATA_W*NUM_CH-1:0] out_buf_end,
  output logic [DATA_W*NUM_CH-1:0] out_wr_ptr
);

  logic [DATA_W-1:0]   control_q, mask_q, ctrl_next, wmask, glob_rd, rd_mux;
  logic [2*NUM_CH-1:0] status_q, pend_q, pend_set, pend_w1c;
  logic [ADDR_W-4:0]   blk;
  logic [2:0]          ofs;
  logic                glob_hit, wr_ctrl, wr_pend, wr_mask, clr_count;
  logic [NUM_CH-1:0]   ch_hit, done_evt, wrap_evt;
  logic [DATA_W-1:0]   ch_rd [NUM_CH];

  assign blk      = address[ADDR_W-1:3];
  assign ofs      = address[2:0];
  assign glob_hit = (blk == '0);
  assign wr_ctrl  = write & glob_hit & (ofs == OFS_CONTROL);
  assign wr_pend  = write & glob_hit & (ofs == OFS_IRQ_PEND);
  assign wr_mask  = write & glob_hit & (ofs == OFS_IRQ_MASK);
  assign clr_count = wr_ctrl & byteenable[DATA_W/8-1] & writedata[DATA_W-1];

  // Expand byte enables to a bit mask and form the global next values
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_W / 8; b++) wmask[8*b +: 8] = {8{byteenable[b]}};
    ctrl_next = (control_q & ~wmask) | (writedata & wmask);
    // The clear strobe is never stored, so CONTROL's MSB always reads 0.
    ctrl_next[DATA_W-1] = 1'b0;
    pend_set = {wrap_evt, done_evt};
    pend_w1c = wr_pend ? (writedata[2*NUM_CH-1:0] & wmask[2*NUM_CH-1:0]) : '0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] BLOCK_ADDR = ADDR_W'(ch_block_base(c));
    logic ch_en;

    assign ch_hit[c] = (blk == BLOCK_ADDR[ADDR_W-1:3]);
    assign ch_en     = control_q[CTRL_GLOBAL_EN] & control_q[CTRL_CH_EN_LSB + c];

    capture_csr_channel #(.DATA_W(DATA_W)) u_channel (
      .clk       (clk),
      .reset     (reset),
      .en        (ch_en),
      .clr_count (clr_count),
      .wr_base   (write & ch_hit[c] & (ofs == OFS_BUF_BASE)),
      .wr_end    (write & ch_hit[c] & (ofs == OFS_BUF_END)),
      .wmask     (wmask),
      .wdata     (writedata),
      .offset    (ofs),
      .pkt_done  (pkt_done[c]),
      .pkt_bytes (pkt_bytes[DATA_W*c +: DATA_W]),
      .rd_data   (ch_rd[c]),
      .buf_base  (out_buf_base[DATA_W*c +: DATA_W]),
      .buf_end   (out_buf_end[DATA_W*c +: DATA_W]),
      .wr_ptr    (out_wr_ptr[DATA_W*c +: DATA_W]),
      .done_evt  (done_evt[c]),
      .wrap_evt  (wrap_evt[c])
    );
  end

  // Global registers: CONTROL, STATUS mirror, pending and mask
  always_ff @(posedge clk) begin
    if (reset) begin
      control_q <= '0;
      status_q  <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
    end else begin
      status_q <= ch_state;
      // Hardware set is OR-ed in after the W1C so a coincident event survives.
      pend_q   <= (pend_q & ~pend_w1c) | pend_set;
      if (wr_ctrl) control_q <= ctrl_next;
      if (wr_mask) mask_q <= (mask_q & ~wmask) | (writedata & wmask);
    end
  end

  // Read-side decode over global words and channel blocks
  always_comb begin
    glob_rd = '0;
    case (ofs)
      OFS_CONTROL:  glob_rd = control_q;
      OFS_STATUS:   glob_rd[2*NUM_CH-1:0] = status_q;
      OFS_IRQ_PEND: glob_rd[2*NUM_CH-1:0] = pend_q;
      OFS_IRQ_MASK: glob_rd = mask_q;
      OFS_VERSION:  glob_rd = VERSION;
      default:      glob_rd = '0;
    endcase
    rd_mux = glob_hit ? glob_rd : '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) rd_mux = ch_rd[c];
    end
  end

  // Registered read response; readdata holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

  // Registered interrupt level
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pend_q & mask_q[2*NUM_CH-1:0]);
  end

  assign out_control = control_q;

endmodule

// File: tb/tb_capture_csr_bank.sv
// Directed self-checking bench for capture_csr_bank (DATA_W=32, NUM_CH=2).
module tb_capture_csr_bank;
  import capture_csr_pkg::*;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 3 + $clog2(NUM_CH + 1);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [ADDR_W-1:0]        address;
  logic                     read, write;
  logic [DATA_W/8-1:0]      byteenable;
  logic [DATA_W-1:0]        writedata, readdata, out_control;
  logic                     readdatavalid, irq;
  logic [2*NUM_CH-1:0]      ch_state;
  logic [NUM_CH-1:0]        pkt_done;
  logic [DATA_W*NUM_CH-1:0] pkt_bytes, out_buf_base, out_buf_end, out_wr_ptr;

  int n_cmp = 0;
  int n_err = 0;

  capture_csr_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .irq           (irq),
    .ch_state      (ch_state),
    .pkt_done      (pkt_done),
    .pkt_bytes     (pkt_bytes),
    .out_control   (out_control),
    .out_buf_base  (out_buf_base),
    .out_buf_end   (out_buf_end),
    .out_wr_ptr    (out_wr_ptr)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address = ADDR_W'(a); writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0; byteenable = '0;
  endtask

  // Returns the data and valid seen one cycle after the read strobe.
  task automatic bus_read(input int a, output logic [31:0] d, output logic v);
    @(negedge clk);
    address = ADDR_W'(a); read = 1'b1;
    @(negedge clk);
    d = readdata; v = readdatavalid; read = 1'b0;
  endtask

  task automatic pulse_pkt(input int ch, input logic [31:0] bytes);
    @(negedge clk);
    pkt_done = '0; pkt_done[ch] = 1'b1; pkt_bytes[32*ch +: 32] = bytes;
    @(negedge clk);
    pkt_done = '0;
  endtask

  task automatic test_reset;
    int addrs [13] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 16, 17, 18, 19};
    logic [31:0] d, exp;
    logic v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({readdata, readdatavalid, irq} !== 34'd0 || out_control !== 32'd0 || out_wr_ptr !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%h rdv=%b irq=%b ctrl=%h ptr=%h expected all zero",
               readdata, readdatavalid, irq, out_control, out_wr_ptr);
    end
    foreach (addrs[i]) begin
      exp = (addrs[i] == 4) ? 32'h0002_0000 : 32'h0;
      bus_read(addrs[i], d, v);
      n_cmp++;
      if (d !== exp || v !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h valid=%b expected %h valid=1", addrs[i], d, v, exp);
      end
    end
    bus_read(4, d, v);
    @(negedge clk);
    n_cmp++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0002_0000) begin
      n_err++;
      $display("FAIL read_hold: got valid=%b data=%h expected valid=0 data=00020000", readdatavalid, readdata);
    end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    address = ADDR_W'(4); read = 1'b1; reset = 1'b1;
    @(negedge clk);
    read = 1'b0; reset = 1'b0;
    n_cmp++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_read: got valid=%b data=%h expected valid=0 data=0", readdatavalid, readdata);
    end
  endtask

  task automatic test_buf_base_lanes;
    logic [31:0] d;
    logic v;
    bus_write(8, 32'hAAAA_1000, 4'b0011);
    bus_read(8, d, v);
    n_cmp++;
    if (d !== 32'h0000_1000) begin n_err++; $display("FAIL base_lanes: got %h expected 00001000", d); end
    bus_read(10, d, v);
    n_cmp++;
    if (d !== 32'h0000_1000) begin n_err++; $display("FAIL ptr_reload: got %h expected 00001000", d); end
    n_cmp++;
    if (out_buf_base[31:0] !== 32'h0000_1000) begin
      n_err++; $display("FAIL out_buf_base: got %h expected 00001000", out_buf_base[31:0]);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    logic v;
    logic [31:0] exp_ptr [3] = '{32'h1060, 32'h10C0, 32'h1020};
    bus_write(0, 32'h0000_0003, 4'b1111);
    bus_write(9, 32'h0000_1100, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      pulse_pkt(0, 32'h60);
      bus_read(10, d, v);
      n_cmp++;
      if (d !== exp_ptr[i]) begin n_err++; $display("FAIL wr_ptr_step%0d: got %h expected %h", i, d, exp_ptr[i]); end
    end
    bus_read(2, d, v);
    n_cmp++;
    if (d !== 32'b101) begin n_err++; $display("FAIL irq_pend_wrap: got %h expected 00000005", d); end
    bus_read(11, d, v);
    n_cmp++;
    if (d !== 32'd3) begin n_err++; $display("FAIL pkt_count3: got %h expected 00000003", d); end
    n_cmp++;
    if (out_wr_ptr[31:0] !== 32'h1020) begin n_err++; $display("FAIL out_wr_ptr: got %h expected 00001020", out_wr_ptr[31:0]); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic v;
    bus_write(2, 32'hF, 4'b1111);
    bus_write(3, 32'h1, 4'b1111);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b expected 0", irq); end
    @(negedge clk);
    pkt_done = 2'b01; pkt_bytes[31:0] = 32'h10;
    @(negedge clk);
    pkt_done = '0;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b expected 0", irq); end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
    // W1C on bit0 in the same cycle as a new ch0 packet
    @(negedge clk);
    address = ADDR_W'(2); writedata = 32'h1; byteenable = 4'b1111; write = 1'b1; pkt_done = 2'b01;
    @(negedge clk);
    write = 1'b0; byteenable = '0; pkt_done = '0;
    bus_read(2, d, v);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL set_beats_w1c: got %h expected 00000001", d); end
    bus_write(2, 32'h1, 4'b1111);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_clear_latency: got %b expected 1", irq); end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    bus_read(10, d, v);
    n_cmp++;
    if (d !== 32'h1040) begin n_err++; $display("FAIL wr_ptr_after_irq: got %h expected 00001040", d); end
    bus_read(11, d, v);
    n_cmp++;
    if (d !== 32'd5) begin n_err++; $display("FAIL pkt_count5: got %h expected 00000005", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic v;
    @(negedge clk);
    address = ADDR_W'(3); writedata = 32'h55; byteenable = 4'b1111; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0; byteenable = '0;
    n_cmp++;
    if (readdata !== 32'h1 || readdatavalid !== 1'b1) begin
      n_err++; $display("FAIL rw_same_cycle: got %h valid=%b expected 00000001 valid=1", readdata, readdatavalid);
    end
    bus_write(3, 32'h12AB_3456, 4'b0100);
    bus_read(3, d, v);
    n_cmp++;
    if (d !== 32'h00AB_0055) begin n_err++; $display("FAIL mask_lane2: got %h expected 00ab0055", d); end
  endtask

  task automatic test_count_clear;
    logic [31:0] d;
    logic v;
    bus_write(0, 32'h0000_0007, 4'b1111);
    pulse_pkt(1, 32'h4);
    bus_read(19, d, v);
    n_cmp++;
    if (d !== 32'd1) begin n_err++; $display("FAIL ch1_count1: got %h expected 00000001", d); end
    @(negedge clk);
    address = ADDR_W'(0); writedata = 32'h8000_0007; byteenable = 4'b1111; write = 1'b1;
    pkt_done = 2'b10; pkt_bytes[63:32] = 32'h4;
    @(negedge clk);
    write = 1'b0; byteenable = '0; pkt_done = '0;
    bus_read(19, d, v);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL clear_beats_inc: got %h expected 00000000", d); end
    bus_read(11, d, v);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL ch0_cleared: got %h expected 00000000", d); end
    bus_read(0, d, v);
    n_cmp++;
    if (d !== 32'h7) begin n_err++; $display("FAIL control_msb: got %h expected 00000007", d); end
    bus_read(18, d, v);
    n_cmp++;
    if (d !== 32'h8) begin n_err++; $display("FAIL ch1_ptr: got %h expected 00000008", d); end
  endtask

  task automatic test_status_disabled;
    logic [31:0] d;
    logic v;
    bus_write(0, 32'h0000_0003, 4'b1111);
    @(negedge clk);
    ch_state = {CH_CAPTURE, CH_IDLE};
    repeat (2) @(negedge clk);
    bus_read(1, d, v);
    n_cmp++;
    if (d !== 32'b1000) begin n_err++; $display("FAIL status_mirror: got %h expected 00000008", d); end
    pulse_pkt(1, 32'h40);
    bus_read(18, d, v);
    n_cmp++;
    if (d !== 32'h8) begin n_err++; $display("FAIL disabled_ptr: got %h expected 00000008", d); end
    bus_read(19, d, v);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL disabled_count: got %h expected 00000000", d); end
    bus_read(31, d, v);
    n_cmp++;
    if (d !== 32'd0 || v !== 1'b1) begin
      n_err++; $display("FAIL unmapped_read: got %h valid=%b expected 00000000 valid=1", d, v);
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; byteenable = '0; writedata = '0;
    ch_state = '0; pkt_done = '0; pkt_bytes = '0;
    test_reset;
    test_reset_mid_read;
    test_buf_base_lanes;
    test_wrap;
    test_irq;
    test_back_to_back;
    test_count_clear;
    test_status_disabled;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
